// File: rtl/elevator_scheduler_if.sv
// Signal bundle between the elevator scheduler and its driver/display side.
// tick and floor_btn are plain levels sampled on every CLK; there is no backpressure.
interface elevator_scheduler_if;
    logic       tick;
    logic [7:0] floor_btn;
    logic [3:0] floor;
    logic [7:0] pending;
    logic [3:0] countdown;
    logic [3:0] status;
    logic       door_open;

    modport master (
        output tick, floor_btn,
        input  floor, pending, countdown, status, door_open
    );

    modport slave (
        input  tick, floor_btn,
        output floor, pending, countdown, status, door_open
    );
endinterface

// File: rtl/elevator_scheduler.sv
// Single-car elevator: latches floor requests, runs a LOOK policy and sequences
// travel and door dwell off a slow tick. status doubles as the FSM state view.
module elevator_scheduler #(
    parameter int FLOORS     = 8,
    parameter int MOVE_TICKS = 4,
    parameter int DOOR_TICKS = 6
) (
    input logic CLK,
    input logic RST_N,
    elevator_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    localparam logic [7:0] FLOOR_MASK = 8'((9'd1 << FLOORS) - 9'd1);
    localparam logic [3:0] MOVE_LOAD  = 4'(MOVE_TICKS);
    localparam logic [3:0] DOOR_LOAD  = 4'(DOOR_TICKS);

    state_t     state;
    logic [3:0] floor_q;
    logic [3:0] cd_q;
    logic [7:0] pend_q;
    logic       dir_up;
    logic       door_q;

    logic [7:0] btn_v, cur_onehot, new_req, pend_all, above_mask, below_mask;
    logic       moving, cur_req, any_up, any_dn, ahead, behind, go, go_up, arrive_hit;
    logic [3:0] next_floor;

    // Direction decisions look at requests including this cycle's presses, so a
    // press seen in IDLE starts the car on the very next edge.
    always_comb begin
        btn_v      = bus.floor_btn & FLOOR_MASK;
        cur_onehot = 8'd1 << floor_q;
        moving     = (state == MOVE_UP) || (state == MOVE_DOWN);
        new_req    = moving ? btn_v : (btn_v & ~cur_onehot);
        pend_all   = pend_q | new_req;
        cur_req    = |(btn_v & cur_onehot);
        below_mask = cur_onehot - 8'd1;
        above_mask = ~(below_mask | cur_onehot);
        any_up     = |(pend_all & above_mask);
        any_dn     = |(pend_all & below_mask);
        ahead      = dir_up ? any_up : any_dn;
        behind     = dir_up ? any_dn : any_up;
        go         = ahead || behind;
        go_up      = ahead ? dir_up : ~dir_up;
        next_floor = (state == MOVE_UP) ? floor_q + 4'd1 : floor_q - 4'd1;
        arrive_hit = pend_q[next_floor[2:0]];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            floor_q <= 4'd0;
            cd_q    <= 4'd0;
            pend_q  <= 8'd0;
            dir_up  <= 1'b1;
            door_q  <= 1'b0;
        end else begin
            pend_q <= pend_all;
            case (state)
                IDLE: begin
                    if (cur_req) begin
                        state  <= DOOR;
                        cd_q   <= DOOR_LOAD;
                        door_q <= 1'b1;
                    end else if (go) begin
                        dir_up <= go_up;
                        state  <= go_up ? MOVE_UP : MOVE_DOWN;
                        cd_q   <= MOVE_LOAD;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (bus.tick) begin
                        if (cd_q == 4'd1) begin
                            floor_q <= next_floor;
                            if (arrive_hit) begin
                                // Clearing the arrival bit overrides a same-cycle press of it.
                                pend_q <= pend_all & ~(8'd1 << next_floor[2:0]);
                                state  <= DOOR;
                                cd_q   <= DOOR_LOAD;
                                door_q <= 1'b1;
                            end else begin
                                cd_q <= MOVE_LOAD;
                            end
                        end else begin
                            cd_q <= cd_q - 4'd1;
                        end
                    end
                end
                DOOR: begin
                    if (cur_req) begin
                        cd_q <= DOOR_LOAD;
                    end else if (bus.tick) begin
                        if (cd_q == 4'd1) begin
                            door_q <= 1'b0;
                            if (go) begin
                                dir_up <= go_up;
                                state  <= go_up ? MOVE_UP : MOVE_DOWN;
                                cd_q   <= MOVE_LOAD;
                            end else begin
                                state <= IDLE;
                                cd_q  <= 4'd0;
                            end
                        end else begin
                            cd_q <= cd_q - 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.floor     = floor_q;
    assign bus.pending   = pend_q;
    assign bus.countdown = cd_q;
    assign bus.status    = {2'b00, state};
    assign bus.door_open = door_q;
endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus random presses/ticks,
// every cycle compared against a floor-by-floor behavioural model.
module tb_elevator_scheduler;
    localparam int FLOORS     = 8;
    localparam int MOVE_TICKS = 4;
    localparam int DOOR_TICKS = 6;

    // clock / reset
    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    elevator_scheduler_if bus();

    elevator_scheduler #(
        .FLOORS(FLOORS), .MOVE_TICKS(MOVE_TICKS), .DOOR_TICKS(DOOR_TICKS)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: 0 idle, 1 up, 2 down, 3 door
    int  m_floor, m_cd, m_st;
    bit  m_up;
    bit  m_req[8];
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_floor = 0;
        m_cd    = 0;
        m_st    = 0;
        m_up    = 1'b1;
        for (int i = 0; i < 8; i++) m_req[i] = 1'b0;
    endtask

    function automatic logic [7:0] model_pending();
        logic [7:0] v = 8'd0;
        for (int i = 0; i < 8; i++) v[i] = m_req[i];
        return v;
    endfunction

    task automatic model_pick_move();
        int n_above = 0;
        int n_below = 0;
        for (int i = 0; i < FLOORS; i++) begin
            if (m_req[i] && i > m_floor) n_above++;
            if (m_req[i] && i < m_floor) n_below++;
        end
        if ((m_up && n_above > 0) || (!m_up && n_below > 0)) begin
            m_st = m_up ? 1 : 2;
            m_cd = MOVE_TICKS;
        end else if (n_above > 0 || n_below > 0) begin
            m_up = !m_up;
            m_st = m_up ? 1 : 2;
            m_cd = MOVE_TICKS;
        end else begin
            m_st = 0;
            m_cd = 0;
        end
    endtask

    task automatic model_step(input logic [7:0] btn, input bit tk);
        bit old_req[8];
        bit moving;
        bit here;
        old_req = m_req;
        moving  = (m_st == 1) || (m_st == 2);
        here    = btn[m_floor];
        for (int i = 0; i < FLOORS; i++)
            if (btn[i] && (moving || i != m_floor)) m_req[i] = 1'b1;
        case (m_st)
            0: begin
                if (here) begin
                    m_st = 3;
                    m_cd = DOOR_TICKS;
                end else begin
                    model_pick_move();
                end
            end
            1, 2: begin
                if (tk) begin
                    if (m_cd == 1) begin
                        m_floor += (m_st == 1) ? 1 : -1;
                        if (old_req[m_floor]) begin
                            m_req[m_floor] = 1'b0;
                            m_st = 3;
                            m_cd = DOOR_TICKS;
                        end else begin
                            m_cd = MOVE_TICKS;
                        end
                    end else begin
                        m_cd--;
                    end
                end
            end
            default: begin
                if (here) m_cd = DOOR_TICKS;
                else if (tk) begin
                    if (m_cd == 1) model_pick_move();
                    else m_cd--;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        check("floor",     32'(bus.floor),     32'(m_floor));
        check("pending",   32'(bus.pending),   32'(model_pending()));
        check("countdown", 32'(bus.countdown), 32'(m_cd));
        check("status",    32'(bus.status),    32'(m_st));
        check("door_open", 32'(bus.door_open), 32'(m_st == 3));
    endtask

    // driver: called at a negedge, returns at the next negedge after checking
    task automatic cycle(input logic [7:0] btn, input bit tk);
        bus.floor_btn = btn;
        bus.tick      = tk;
        @(posedge CLK);
        model_step(btn, tk);
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(8'h00, 1'b1);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        bus.floor_btn = 8'h00;
        bus.tick = 1'b0;
        @(negedge CLK);
        model_reset();
        check_outputs();
        RST_N = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev;
        logic [7:0] btn;

        RST_N = 1'b0;
        bus.floor_btn = 8'h00;
        bus.tick = 1'b0;
        repeat (2) @(negedge CLK);
        model_reset();
        check("rst_floor",   32'(bus.floor),     32'd0);
        check("rst_pending", 32'(bus.pending),   32'd0);
        check("rst_cd",      32'(bus.countdown), 32'd0);
        check("rst_status",  32'(bus.status),    32'd0);
        check("rst_door",    32'(bus.door_open), 32'd0);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) cycle(8'h00, 1'b0);
        cycle(8'h00, 1'b1);

        // door request at current floor
        cycle(8'h01, 1'b0);
        check("door0_pending", 32'(bus.pending),   32'h00);
        check("door0_status",  32'(bus.status),    32'd3);
        check("door0_open",    32'(bus.door_open), 32'd1);
        check("door0_cd",      32'(bus.countdown), 32'd6);
        ticks(6);
        check("door0_close", 32'(bus.status), 32'd0);

        // single trip 0 -> 3 with idle cycles between ticks
        cycle(8'h08, 1'b0);
        check("trip_pending", 32'(bus.pending),   32'h08);
        check("trip_status",  32'(bus.status),    32'd1);
        check("trip_cd",      32'(bus.countdown), 32'd4);
        for (int t = 1; t <= 12; t++) begin
            cycle(8'h00, 1'b1);
            cycle(8'h00, 1'b0);
            if (t % 4 == 0) check("trip_floor", 32'(bus.floor), 32'(t / 4));
        end
        check("trip_arr_status",  32'(bus.status),    32'd3);
        check("trip_arr_cd",      32'(bus.countdown), 32'd6);
        check("trip_arr_pending", 32'(bus.pending),   32'h00);
        ticks(6);
        check("trip_idle", 32'(bus.status), 32'd0);

        // LOOK ordering from floor 2 heading up with {1,4,6} pending
        do_reset();
        cycle(8'h04, 1'b0);
        ticks(8);
        check("look_at2", 32'(bus.floor), 32'd2);
        cycle(8'h52, 1'b0);
        check("look_pend", 32'(bus.pending), 32'h52);
        exp_q = '{4'd1, 4'd3, 4'd1, 4'd3, 4'd2, 4'd3, 4'd0};
        prev = bus.status;
        for (int i = 0; i < 400; i++) begin
            cycle(8'h00, 1'($urandom_range(0, 1)));
            if (bus.status != prev) begin
                if (exp_q.size() == 0) check("look_extra", 32'(bus.status), 32'hF);
                else check("look_seq", 32'(bus.status), 32'(exp_q.pop_front()));
                prev = bus.status;
            end
            if (bus.status == 4'd0) break;
        end
        check("look_left",  32'(exp_q.size()), 32'd0);
        check("look_end",   32'(bus.status),    32'd0);
        check("look_floor", 32'(bus.floor),     32'd1);

        // door re-open at floor 5, reload coinciding with a tick
        cycle(8'h20, 1'b0);
        ticks(16);
        check("reopen_at5", 32'(bus.floor), 32'd5);
        ticks(4);
        check("reopen_cd2", 32'(bus.countdown), 32'd2);
        cycle(8'h20, 1'b1);
        check("reopen_cd6", 32'(bus.countdown), 32'd6);
        ticks(5);
        check("reopen_still", 32'(bus.status), 32'd3);
        ticks(1);
        check("reopen_close", 32'(bus.status), 32'd0);

        // asynchronous reset mid-move
        do_reset();
        cycle(8'h80, 1'b0);
        ticks(12);
        check("arst_pre_floor",  32'(bus.floor),   32'd3);
        check("arst_pre_status", 32'(bus.status),  32'd1);
        check("arst_pre_pend",   32'(bus.pending), 32'h80);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_floor",   32'(bus.floor),     32'd0);
        check("arst_pending", 32'(bus.pending),   32'd0);
        check("arst_cd",      32'(bus.countdown), 32'd0);
        check("arst_status",  32'(bus.status),    32'd0);
        check("arst_door",    32'(bus.door_open), 32'd0);
        @(negedge CLK);
        model_reset();
        RST_N = 1'b1;

        // random presses and ticks
        for (int i = 0; i < 3000; i++) begin
            btn = 8'h00;
            if ($urandom_range(0, 7) == 0) btn = 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) btn = btn | 8'(1 << m_floor);
            if ($urandom_range(0, 99) == 0) btn = 8'($urandom);
            cycle(btn, 1'($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
